memory_arbiter: RTL and testbench

MEMORY_ARBITER -- requirements
Module: memory_arbiter

---
 rtl/memory_arbiter.sv | 150 +++++++++++++++
 tb/tb_memory_arbiter.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_arbiter.sv
// Two-CPU memory arbiter: one RAM transaction at a time, dWEN > dREN > iREN, round-robin ties.
// Define MEMARB_SNOOP_EN to insert a one-cycle snoop of the other cache ahead of data reads.
module memory_arbiter #(
    parameter int unsigned CPUS = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0]       dREN,
    input  logic [CPUS-1:0]       dWEN,
    input  logic [CPUS-1:0][31:0] iaddr,
    input  logic [CPUS-1:0][31:0] daddr,
    input  logic [CPUS-1:0][31:0] dstore,
    input  logic [CPUS-1:0]       ccwrite,
    input  logic [CPUS-1:0]       cctrans,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0]       dwait,
    output logic [CPUS-1:0][31:0] iload,
    output logic [CPUS-1:0][31:0] dload,
    output logic [CPUS-1:0]       ccwait,
    output logic [CPUS-1:0]       ccinv,
    output logic [CPUS-1:0][31:0] ccsnoopaddr,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);

    localparam logic [1:0] RamAccess = 2'd2;

    typedef enum logic [2:0] {StIdle, StSnoop, StDread, StDwrite, StIfetch} state_e;

    state_e state_q;
    logic   g_q;
    logic   rr_q;
    logic   live;
    logic   done;

    // CPU ptr wins when it requests, otherwise the other one does.
    function automatic logic pick(input logic [CPUS-1:0] req, input logic ptr);
        return req[ptr] ? ptr : ~ptr;
    endfunction

    always_comb begin
        case (state_q)
            StSnoop, StDread: live = dREN[g_q];
            StDwrite:         live = dWEN[g_q];
            StIfetch:         live = iREN[g_q];
            default:          live = 1'b0;
        endcase
    end

    assign done = live && (ramstate == RamAccess) && (state_q != StSnoop);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            g_q     <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|dWEN) begin
                        g_q     <= pick(dWEN, rr_q);
                        state_q <= StDwrite;
                    end else if (|dREN) begin
                        g_q     <= pick(dREN, rr_q);
`ifdef MEMARB_SNOOP_EN
                        state_q <= StSnoop;
`else
                        state_q <= StDread;
`endif
                    end else if (|iREN) begin
                        g_q     <= pick(iREN, rr_q);
                        state_q <= StIfetch;
                    end
                end
                StSnoop: state_q <= live ? StDread : StIdle;
                default: begin
                    // A dropped request aborts without touching the round-robin pointer.
                    if (!live) begin
                        state_q <= StIdle;
                    end else if (done) begin
                        state_q <= StIdle;
                        rr_q    <= ~g_q;
                    end
                end
            endcase
        end
    end

`ifdef MEMARB_SNOOP_EN
    logic other;
    assign other = ~g_q;
`else
    logic unused_cc;
    assign unused_cc = ^{ccwrite, cctrans};
`endif

    always_comb begin
        iwait       = '1;
        dwait       = '1;
        iload       = '0;
        dload       = '0;
        ccwait      = '0;
        ccinv       = '0;
        ccsnoopaddr = '0;
        ramREN      = 1'b0;
        ramWEN      = 1'b0;
        ramaddr     = '0;
        ramstore    = '0;
        if (live) begin
            case (state_q)
                StSnoop: begin
`ifdef MEMARB_SNOOP_EN
                    ccwait[other]      = 1'b1;
                    ccsnoopaddr[other] = daddr[g_q];
                    ccinv[other]       = ccwrite[g_q] & cctrans[g_q];
`endif
                end
                StDread: begin
                    ramREN  = 1'b1;
                    ramaddr = daddr[g_q];
                    if (done) begin
                        dwait[g_q] = 1'b0;
                        dload[g_q] = ramload;
                    end
                end
                StDwrite: begin
                    ramWEN   = 1'b1;
                    ramaddr  = daddr[g_q];
                    ramstore = dstore[g_q];
                    if (done) dwait[g_q] = 1'b0;
                end
                StIfetch: begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr[g_q];
                    if (done) begin
                        iwait[g_q] = 1'b0;
                        iload[g_q] = ramload;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed scenarios plus randomized traffic against a transaction model.
module tb_memory_arbiter;

    localparam logic [1:0] RS_FREE = 2'd0, RS_BUSY = 2'd1, RS_ACCESS = 2'd2, RS_ERROR = 2'd3;
`ifdef MEMARB_SNOOP_EN
    localparam bit SnoopEn = 1'b1;
`else
    localparam bit SnoopEn = 1'b0;
`endif

    logic CLK, RST;
    logic [1:0]       iREN, dREN, dWEN, ccwrite, cctrans;
    logic [1:0][31:0] iaddr, daddr, dstore;
    logic [1:0]       iwait, dwait, ccwait, ccinv;
    logic [1:0][31:0] iload, dload, ccsnoopaddr;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int n_cmp = 0;
    int n_err = 0;

    memory_arbiter #(.CPUS(2)) dut (
        .CLK(CLK), .RST(RST), .iREN(iREN), .dREN(dREN), .dWEN(dWEN),
        .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .ccwrite(ccwrite), .cctrans(cctrans),
        .iwait(iwait), .dwait(dwait), .iload(iload), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clr();
        RST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_ACCESS;
    endtask

    task automatic do_reset();
        clr();
        RST = 1'b1;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        clr();
        iREN = '1; dREN = '1; dWEN = '1;
        daddr[0] = 32'h44; dstore[0] = 32'h55;
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        @(negedge CLK);
        n_cmp++;
        if ({iwait, dwait, ramREN, ramWEN, ccwait, ccinv} !== 10'b1111_0000_00) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b required %b",
                     {iwait, dwait, ramREN, ramWEN, ccwait, ccinv}, 10'b1111_0000_00);
        end
        n_cmp++;
        if ({ramaddr, ramstore, iload, dload, ccsnoopaddr} !== '0) begin
            n_err++;
            $display("FAIL reset_data: got %h required 0",
                     {ramaddr, ramstore, iload, dload, ccsnoopaddr});
        end
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramWEN, dwait, ramaddr, ramstore} !== {1'b1, 2'b10, 32'h44, 32'h55}) begin
            n_err++;
            $display("FAIL first_arb: got wen=%b dwait=%b addr=%h store=%h required 1 10 44 55",
                     ramWEN, dwait, ramaddr, ramstore);
        end
    endtask

    task automatic test_read(input int cpu);
        logic [1:0] ew, eo;
        logic [31:0] eload;
        ew = 2'b11; ew[cpu] = 1'b0;
        eo = 2'b00; eo[1-cpu] = 1'b1;
        eload = 32'hA5A5_0000 + cpu;
        do_reset();
        dREN[cpu] = 1'b1; daddr[cpu] = 32'h100; ccwrite[cpu] = 1'b1; cctrans[cpu] = 1'b1;
        ramload = eload;
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, dwait} !== 3'b011) begin
            n_err++;
            $display("FAIL read_idle cpu%0d: got ren=%b dwait=%b required 0 11", cpu, ramREN, dwait);
        end
        step();
`ifdef MEMARB_SNOOP_EN
        @(negedge CLK);
        n_cmp++;
        if ({ccwait, ccinv, ccsnoopaddr[1-cpu], ramREN, dwait} !== {eo, eo, 32'h100, 1'b0, 2'b11})
        begin
            n_err++;
            $display("FAIL snoop cpu%0d: got ccwait=%b ccinv=%b saddr=%h ren=%b dwait=%b", cpu,
                     ccwait, ccinv, ccsnoopaddr[1-cpu], ramREN, dwait);
        end
        step();
`endif
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, ramaddr, dwait, dload[cpu], ccwait} !== {1'b1, 32'h100, ew, eload, 2'b00})
        begin
            n_err++;
            $display("FAIL dread cpu%0d: got ren=%b addr=%h dwait=%b dload=%h ccwait=%b req %b %h",
                     cpu, ramREN, ramaddr, dwait, dload[cpu], ccwait, ew, eload);
        end
    endtask

    task automatic test_round_robin();
        int exp;
        do_reset();
        iREN = 2'b11; iaddr[0] = 32'h10; iaddr[1] = 32'h20;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            n_cmp++;
            if ({ramREN, iwait} !== 3'b011) begin
                n_err++;
                $display("FAIL rr_idle %0d: got ren=%b iwait=%b required 0 11", k, ramREN, iwait);
            end
            step();
            exp = k % 2;
            ramload = $urandom;
            @(negedge CLK);
            n_cmp++;
            if (ramaddr !== (exp == 1 ? 32'h20 : 32'h10) || iwait !== (exp == 1 ? 2'b01 : 2'b10)
                || iload[exp] !== ramload) begin
                n_err++;
                $display("FAIL rr_grant %0d: got addr=%h iwait=%b iload=%h required cpu%0d", k,
                         ramaddr, iwait, iload[exp], exp);
            end
            step();
        end
    endtask

    task automatic test_priority();
        do_reset();
        dWEN = 2'b10; daddr[1] = 32'h200; dstore[1] = 32'hDEAD_BEEF;
        dREN = 2'b01; daddr[0] = 32'h300; iREN = 2'b01; iaddr[0] = 32'h400;
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramWEN, ramREN, ramaddr, ramstore, dwait, iwait} !==
            {1'b1, 1'b0, 32'h200, 32'hDEAD_BEEF, 2'b01, 2'b11}) begin
            n_err++;
            $display("FAIL prio_write: got wen=%b ren=%b addr=%h store=%h dwait=%b iwait=%b",
                     ramWEN, ramREN, ramaddr, ramstore, dwait, iwait);
        end
        step();
        dWEN = 2'b00;
        step();
        if (SnoopEn) step();
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, ramWEN, ramaddr, dwait, iwait} !== {1'b1, 1'b0, 32'h300, 2'b10, 2'b11}) begin
            n_err++;
            $display("FAIL prio_read: got ren=%b wen=%b addr=%h dwait=%b iwait=%b",
                     ramREN, ramWEN, ramaddr, dwait, iwait);
        end
        step();
        dREN = 2'b00;
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, ramaddr, iwait} !== {1'b1, 32'h400, 2'b10}) begin
            n_err++;
            $display("FAIL prio_fetch: got ren=%b addr=%h iwait=%b required 1 400 10",
                     ramREN, ramaddr, iwait);
        end
    endtask

    task automatic test_wait_states();
        logic [1:0] hold [3];
        hold = '{RS_BUSY, RS_FREE, RS_ERROR};
        do_reset();
        iREN = 2'b01; iaddr[0] = 32'h80; ramstate = RS_BUSY; ramload = 32'h1234;
        step();
        for (int i = 0; i < 3; i++) begin
            ramstate = hold[i];
            @(negedge CLK);
            n_cmp++;
            if ({iwait, ramREN, ramaddr, iload} !== {2'b11, 1'b1, 32'h80, 64'h0}) begin
                n_err++;
                $display("FAIL wait_hold %0d: got iwait=%b ren=%b addr=%h iload=%h", i, iwait,
                         ramREN, ramaddr, iload);
            end
            step();
        end
        ramstate = RS_ACCESS;
        @(negedge CLK);
        n_cmp++;
        if ({iwait, iload[0]} !== {2'b10, 32'h1234}) begin
            n_err++;
            $display("FAIL wait_done: got iwait=%b iload=%h required 10 1234", iwait, iload[0]);
        end
    endtask

    task automatic test_abort();
        // Reset in the middle of a read.
        do_reset();
        iREN = 2'b01;
        step();
        step();
        iREN = 2'b00; dREN = 2'b11; daddr[0] = 32'h500; daddr[1] = 32'h600; ramstate = RS_BUSY;
        step();
        if (SnoopEn) step();
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, ramaddr} !== {1'b1, 32'h600}) begin
            n_err++;
            $display("FAIL abort_rr1: got ren=%b addr=%h required 1 600", ramREN, ramaddr);
        end
        RST = 1'b1;
        step();
        RST = 1'b0; dREN = 2'b00; iREN = 2'b11; iaddr[0] = 32'h700; iaddr[1] = 32'h800;
        ramstate = RS_ACCESS;
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, dwait, iwait} !== 5'b0_11_11) begin
            n_err++;
            $display("FAIL rst_mid: got ren=%b dwait=%b iwait=%b required 0 11 11",
                     ramREN, dwait, iwait);
        end
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramaddr, iwait} !== {32'h700, 2'b10}) begin
            n_err++;
            $display("FAIL rst_rr: got addr=%h iwait=%b required 700 10", ramaddr, iwait);
        end
        // Requester drops its read mid-transaction.
        do_reset();
        dREN = 2'b01; daddr[0] = 32'h900; ramstate = RS_BUSY; ramload = 32'hCAFE;
        step();
        if (SnoopEn) step();
        step();
        dREN = 2'b00; ramstate = RS_ACCESS;
        @(negedge CLK);
        n_cmp++;
        if ({dwait, dload} !== {2'b11, 64'h0}) begin
            n_err++;
            $display("FAIL abort_nodone: got dwait=%b dload=%h required 11 0", dwait, dload);
        end
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramREN, dwait} !== 3'b011) begin
            n_err++;
            $display("FAIL abort_idle: got ren=%b dwait=%b required 0 11", ramREN, dwait);
        end
        iREN = 2'b11; iaddr[0] = 32'hA00; iaddr[1] = 32'hB00;
        step();
        @(negedge CLK);
        n_cmp++;
        if ({ramaddr, iwait} !== {32'hA00, 2'b10}) begin
            n_err++;
            $display("FAIL abort_rr: got addr=%h iwait=%b required A00 10", ramaddr, iwait);
        end
    endtask

    task automatic test_random();
        bit m_busy, m_snoop, held, fin;
        int m_kind, m_cpu, m_rr, kind;
        logic [1:0] req;
        logic [1:0] e_iw, e_dw, e_ccw, e_cci;
        logic [1:0][31:0] e_il, e_dl, e_csa;
        logic e_ren, e_wen;
        logic [31:0] e_addr, e_store;
        do_reset();
        m_busy = 0; m_snoop = 0; m_rr = 0; m_kind = 0; m_cpu = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            RST = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) begin
                iREN = 2'($urandom); dREN = 2'($urandom); dWEN = 2'($urandom & $urandom);
            end
            iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom};
            dstore = {$urandom, $urandom}; ramload = $urandom;
            ccwrite = 2'($urandom); cctrans = 2'($urandom);
            ramstate = ($urandom_range(0, 9) < 6) ? RS_ACCESS : 2'($urandom);
            e_iw = '1; e_dw = '1; e_ccw = '0; e_cci = '0; e_il = '0; e_dl = '0; e_csa = '0;
            e_ren = 0; e_wen = 0; e_addr = '0; e_store = '0; fin = 0; held = 0;
            if (m_busy) begin
                held = (m_kind == 0) ? dWEN[m_cpu] : (m_kind == 1) ? dREN[m_cpu] : iREN[m_cpu];
                if (held && m_snoop) begin
                    e_ccw[1-m_cpu] = 1'b1;
                    e_csa[1-m_cpu] = daddr[m_cpu];
                    e_cci[1-m_cpu] = ccwrite[m_cpu] & cctrans[m_cpu];
                end else if (held) begin
                    fin = (ramstate == RS_ACCESS);
                    if (m_kind == 0) begin
                        e_wen = 1; e_addr = daddr[m_cpu]; e_store = dstore[m_cpu];
                        if (fin) e_dw[m_cpu] = 1'b0;
                    end else if (m_kind == 1) begin
                        e_ren = 1; e_addr = daddr[m_cpu];
                        if (fin) begin e_dw[m_cpu] = 1'b0; e_dl[m_cpu] = ramload; end
                    end else begin
                        e_ren = 1; e_addr = iaddr[m_cpu];
                        if (fin) begin e_iw[m_cpu] = 1'b0; e_il[m_cpu] = ramload; end
                    end
                end
            end
            @(negedge CLK);
            n_cmp++;
            if ({iwait, dwait, ramREN, ramWEN, ccwait, ccinv} !==
                {e_iw, e_dw, e_ren, e_wen, e_ccw, e_cci}) begin
                n_err++;
                $display("FAIL rand_ctrl cyc%0d: got %b required %b", cyc,
                         {iwait, dwait, ramREN, ramWEN, ccwait, ccinv},
                         {e_iw, e_dw, e_ren, e_wen, e_ccw, e_cci});
            end
            n_cmp++;
            if ({ramaddr, ramstore} !== {e_addr, e_store}) begin
                n_err++;
                $display("FAIL rand_ram cyc%0d: got %h %h required %h %h", cyc, ramaddr,
                         ramstore, e_addr, e_store);
            end
            n_cmp++;
            if ({iload, dload, ccsnoopaddr} !== {e_il, e_dl, e_csa}) begin
                n_err++;
                $display("FAIL rand_data cyc%0d: got %h required %h", cyc,
                         {iload, dload, ccsnoopaddr}, {e_il, e_dl, e_csa});
            end
            // Advance the transaction model across the clock edge.
            if (RST) begin
                m_busy = 0; m_snoop = 0; m_rr = 0;
            end else if (!m_busy) begin
                kind = -1; req = '0;
                if (dWEN != 0) begin kind = 0; req = dWEN; end
                else if (dREN != 0) begin kind = 1; req = dREN; end
                else if (iREN != 0) begin kind = 2; req = iREN; end
                if (kind >= 0) begin
                    m_busy = 1; m_kind = kind;
                    m_cpu = req[m_rr] ? m_rr : 1 - m_rr;
                    m_snoop = (kind == 1) && SnoopEn;
                end
            end else if (!held) begin
                m_busy = 0; m_snoop = 0;
            end else if (m_snoop) begin
                m_snoop = 0;
            end else if (fin) begin
                m_busy = 0; m_rr = 1 - m_cpu;
            end
            step();
        end
        RST = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read(0);
        test_read(1);
        test_round_robin();
        test_priority();
        test_wait_states();
        test_abort();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
